// File: rtl/key_serializer_if.sv
// Purpose: code-in / key-out bundle between a code source and key_serializer.
// Latency: none, this is wiring only.
// Backpressure: code_ready tells the source when an offered code will be taken.
interface key_serializer_if #(
    parameter int CODE_W = 5
);
    logic [CODE_W-1:0] code_in;
    logic              code_valid;
    logic              abort;
    logic              code_ready;
    logic              key;
    logic              key_valid;
    logic              busy;
    logic              done;

    modport master (
        output code_in, code_valid, abort,
        input  code_ready, key, key_valid, busy, done
    );

    modport slave (
        input  code_in, code_valid, abort,
        output code_ready, key, key_valid, busy, done
    );
endinterface

// File: rtl/key_serializer.sv
// Purpose: shifts a parallel unlock code out LSB first on key, then forces an idle gap.
// Latency: bit 0 appears the cycle after acceptance; one bit per cycle, then GAP idle cycles.
// Backpressure: code_ready is high only in IDLE; offers at any other time are ignored, never queued.
module key_serializer #(
    parameter int   CODE_W     = 5,
    parameter int   GAP        = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    key_serializer_if.slave   bus
);

    localparam int             BW       = $clog2(CODE_W);
    localparam logic [BW-1:0]  LAST_BIT = BW'(CODE_W - 1);
    localparam logic [BW-1:0]  PRE_LAST = BW'(CODE_W - 2);
    localparam logic [BW-1:0]  ONE_B    = BW'(1);
    // With GAP=0 the gap state is never entered, so its terminal value is irrelevant.
    localparam logic [3:0]     GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t              r_state;
    logic [CODE_W-1:0]   r_shift;
    logic [BW-1:0]       r_bit_cnt;
    logic [3:0]          r_gap_cnt;
    logic                r_key;
    logic                r_key_valid;
    logic                r_busy;
    logic                r_done;

    assign bus.code_ready = (r_state == ST_IDLE);
    assign bus.key        = r_key;
    assign bus.key_valid  = r_key_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

    // Serializer FSM: accept in IDLE, present one bit per cycle in SHIFT, hold idle level in GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_key       <= IDLE_LEVEL;
            r_key_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // done is a single-cycle marker; only the advance onto the last bit re-arms it.
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // abort in IDLE vetoes acceptance on the same edge.
                    if (bus.code_valid && !bus.abort) begin
                        r_shift     <= bus.code_in;
                        r_bit_cnt   <= '0;
                        r_key       <= bus.code_in[0];
                        r_key_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bus.abort) begin
                        r_key       <= IDLE_LEVEL;
                        r_key_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (r_bit_cnt == LAST_BIT) begin
                        r_key       <= IDLE_LEVEL;
                        r_key_valid <= 1'b0;
                        if (GAP == 0) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_gap_cnt <= '0;
                            r_state   <= ST_GAP;
                        end
                    end else begin
                        // r_shift[0] always mirrors the bit on key, so the next bit is r_shift[1].
                        r_bit_cnt <= r_bit_cnt + ONE_B;
                        r_shift   <= r_shift >> 1;
                        r_key     <= r_shift[1];
                        r_done    <= (r_bit_cnt == PRE_LAST);
                    end
                end
                ST_GAP: begin
                    if (bus.abort || (r_gap_cnt == GAP_LAST)) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                default: begin
                    r_key       <= IDLE_LEVEL;
                    r_key_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
